// File: rtl/mips_pkg.sv
// mips_pkg: shared types, widths and helpers for the MIPS pipeline control blocks
package mips_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} hazard_state_t;
  localparam int REG_W = 5;
  localparam int CNT_W_DEF = 16;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v == lim) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/hazard_lu_detect.sv
// hazard_lu_detect: combinational load-use hazard comparator between ID and ID/EX
// ports: ID source fields (id_rs, id_rt, id_uses_rt), ID/EX load info (idex_MemRead, idex_rt) -> hazard
module hazard_lu_detect
  import mips_pkg::*;
(
  input  logic             idex_MemRead,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hazard
);
  assign hazard = idex_MemRead && idex_rt != '0 &&
                  (idex_rt == id_rs || (id_uses_rt && idex_rt == id_rt));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline enable/flush sequencing for load-use stalls, MEM-stage branch flushes and memory freezes
// ports: clk/rst; ID and ID/EX hazard fields; EX/MEM branch and memory controls; mem_ready in;
//        per-register enables and flushes, mem_req, sticky mem_err and saturating stall/flush counters out
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_MemRead,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             exmem_Branch,
  input  logic             exmem_zero,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  hazard_state_t   state;
  logic [TO_W-1:0] timer;
  logic            memop, lu, frz, br, lus, tmo, stall_inc;
  hazard_lu_detect u_lu (
    .idex_MemRead(idex_MemRead),
    .idex_rt     (idex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hazard      (lu)
  );
  assign memop = exmem_MemRead | exmem_MemWrite;
  assign frz = state == ERROR || (state == MEM_WAIT && !mem_ready) ||
               (state == RUN && memop && !mem_ready);
  // branch and load-use only act in RUN and only when memory is not freezing the pipe
  assign br  = state == RUN && !frz && exmem_Branch && exmem_zero;
  assign lus = state == RUN && !frz && !br && lu;
  assign tmo = MEM_TIMEOUT != 0 && timer == TO_W'(MEM_TIMEOUT);
  assign stall_inc = (frz && state != ERROR) || lus;
  assign pc_write    = rst || (!frz && !lus);
  assign ifid_en     = rst || (!frz && !lus);
  assign idex_en     = rst || !frz;
  assign exmem_en    = rst || !frz;
  assign ifid_flush  = rst || br;
  assign idex_flush  = rst || br || lus;
  assign exmem_flush = rst || br;
  assign mem_req     = !rst && state != ERROR && memop;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      timer     <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= CNT_W'(sat_inc(32'(stall_cnt), 32'(CNT_MAX)));
      if (br) flush_cnt <= CNT_W'(sat_inc(32'(flush_cnt), 32'(CNT_MAX)));
      if (state == RUN && memop && !mem_ready) begin
        state <= MEM_WAIT;
        timer <= TO_W'(1);
      end else if (state == MEM_WAIT && mem_ready) begin
        state <= RUN;
        timer <= '0;
      end else if (state == MEM_WAIT && tmo) begin
        state   <= ERROR;
        mem_err <= 1'b1;
      end else if (state == MEM_WAIT) begin
        timer <= timer + TO_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a behavioural pipeline-control model
module tb_hazard_ctrl;
  localparam int CW = 4;
  localparam int TO = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic id_uses_rt, idex_MemRead, exmem_Branch, exmem_zero, exmem_MemRead, exmem_MemWrite, mem_ready;
  logic pc_write, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, mem_req, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0;
  int errors = 0;
  bit m_wait, m_dead, m_err, n_wait, n_dead, n_err;
  int m_wt, m_stall, m_flush, n_wt, n_stall, n_flush;
  logic [8:0] exp_o;
  logic [16:0] obs, expv;
  always #5 clk = ~clk;
  hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt), .exmem_Branch(exmem_Branch),
    .exmem_zero(exmem_zero), .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .mem_ready(mem_ready), .pc_write(pc_write), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .mem_req(mem_req), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  assign obs = {pc_write, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
                mem_req, mem_err, stall_cnt, flush_cnt};
  function automatic int sat(input int v);
    return v >= CMAX ? CMAX : v + 1;
  endfunction
  task automatic clear_in();
    rst = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; idex_MemRead = 0; idex_rt = 0;
    exmem_Branch = 0; exmem_zero = 0; exmem_MemRead = 0; exmem_MemWrite = 0; mem_ready = 0;
  endtask
  // expected outputs for the current cycle and the model's view after the next edge
  task automatic eval();
    bit memop, load_use;
    memop = exmem_MemRead || exmem_MemWrite;
    load_use = idex_MemRead && idex_rt != 0 && (idex_rt == id_rs || (id_uses_rt && idex_rt == id_rt));
    n_wait = m_wait; n_dead = m_dead; n_err = m_err; n_wt = m_wt; n_stall = m_stall; n_flush = m_flush;
    if (rst) begin
      exp_o = {8'b1111_1110, m_err};
      n_wait = 0; n_dead = 0; n_err = 0; n_wt = 0; n_stall = 0; n_flush = 0;
    end else if (m_dead) begin
      exp_o = 9'b0000_0000_1;
    end else if ((m_wait || memop) && !mem_ready) begin
      exp_o = {7'b0, memop, m_err};
      n_stall = sat(m_stall);
      if (!m_wait) begin n_wait = 1; n_wt = 1; end
      else if (m_wt == TO) begin n_dead = 1; n_err = 1; end
      else n_wt = m_wt + 1;
    end else if (m_wait) begin
      exp_o = {7'b1101010, memop, m_err};
      n_wait = 0; n_wt = 0;
    end else if (exmem_Branch && exmem_zero) begin
      exp_o = {7'b1111111, memop, m_err};
      n_flush = sat(m_flush);
    end else if (load_use) begin
      exp_o = {7'b0001110, memop, m_err};
      n_stall = sat(m_stall);
    end else begin
      exp_o = {7'b1101010, memop, m_err};
    end
    expv = {exp_o, CW'(m_stall), CW'(m_flush)};
    #3;
  endtask
  task automatic tick();
    @(posedge clk);
    m_wait = n_wait; m_dead = n_dead; m_err = n_err; m_wt = n_wt; m_stall = n_stall; m_flush = n_flush;
    #1;
  endtask
  task automatic test_reset();
    clear_in();
    rst = 1;
    eval(); tick();
    for (int i = 0; i < 3; i++) begin
      exmem_MemRead = 1'($urandom); exmem_Branch = 1; exmem_zero = 1; idex_MemRead = 1;
      idex_rt = 5'd3; id_rs = 5'd3;
      eval();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset[%0d] got %b exp %b", i, obs, expv); end
      tick();
    end
    clear_in();
  endtask
  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      clear_in();
      idex_MemRead = (i != 1); idex_rt = (i == 2) ? 5'd0 : 5'd8; id_rs = (i == 3) ? 5'd1 : 5'd8;
      id_rt = 5'd8; id_uses_rt = (i == 3);
      eval();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL load_use[%0d] got %b exp %b", i, obs, expv); end
      tick();
    end
    clear_in();
    eval();
    checks++;
    if (stall_cnt !== CW'(2)) begin errors++; $display("FAIL load_use_cnt got %0d exp 2", stall_cnt); end
    tick();
  endtask
  task automatic test_branch();
    clear_in();
    exmem_Branch = 1; exmem_zero = 1; idex_MemRead = 1; idex_rt = 5'd9; id_rs = 5'd9;
    eval();
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL branch got %b exp %b", obs, expv); end
    tick();
    clear_in();
    exmem_Branch = 1; exmem_zero = 0;
    eval();
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL branch_not_taken got %b exp %b", obs, expv); end
    tick();
  endtask
  task automatic test_mem_wait();
    for (int i = 0; i < 5; i++) begin
      clear_in();
      exmem_MemRead = (i < 4); mem_ready = (i == 3);
      eval();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL mem_wait[%0d] got %b exp %b", i, obs, expv); end
      tick();
    end
    clear_in();
    exmem_MemWrite = 1; mem_ready = 1;
    eval();
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL mem_single got %b exp %b", obs, expv); end
    tick();
  endtask
  task automatic test_timeout();
    clear_in(); rst = 1; eval(); tick();
    for (int i = 0; i < 9; i++) begin
      clear_in();
      exmem_MemRead = 1;
      eval();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL timeout[%0d] got %b exp %b", i, obs, expv); end
      tick();
    end
    checks++;
    if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", mem_err); end
    clear_in(); rst = 1; eval(); tick();
    clear_in();
    eval();
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL timeout_recover got %b exp %b", obs, expv); end
    tick();
  endtask
  task automatic test_saturation();
    clear_in(); rst = 1; eval(); tick();
    for (int i = 0; i < 20; i++) begin
      clear_in();
      idex_MemRead = 1; idex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1;
      eval();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL saturate[%0d] got %b exp %b", i, obs, expv); end
      tick();
    end
    clear_in();
    eval();
    checks++;
    if (stall_cnt !== CW'(CMAX)) begin errors++; $display("FAIL saturate_final got %0d exp %0d", stall_cnt, CMAX); end
    tick();
  endtask
  task automatic test_reset_mid_wait();
    clear_in(); rst = 1; eval(); tick();
    for (int i = 0; i < 5; i++) begin
      clear_in();
      exmem_MemRead = (i < 3); rst = (i == 2);
      eval();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_wait[%0d] got %b exp %b", i, obs, expv); end
      tick();
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); idex_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom); idex_MemRead = 1'($urandom);
      exmem_Branch = ($urandom_range(0, 3) == 0); exmem_zero = 1'($urandom);
      exmem_MemRead = ($urandom_range(0, 4) == 0); exmem_MemWrite = ($urandom_range(0, 6) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      eval();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random[%0d] got %b exp %b", i, obs, expv); end
      tick();
    end
  endtask
  initial begin
    clear_in();
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives write-enable and flush (bubble) controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Handles three events:
  - load-use stall;
  - taken-branch flush, with the branch resolved in MEM;
  - multi-cycle data-memory freeze, with timeout.
- Keeps saturating stall and flush statistics counters.

Parameters:
CNT_W, 16, width of stall_cnt/flush_cnt
MEM_TIMEOUT, 64, max MEM_WAIT cycles before error; 0 disables timeout
TO_W, 8, width of internal wait timer; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
idex_MemRead  in  1  MemRead held in the ID/EX register
idex_rt  in  5  rt (load destination) held in the ID/EX register
exmem_Branch  in  1  Branch held in the EX/MEM register
exmem_zero  in  1  ALU zero held in the EX/MEM register
exmem_MemRead  in  1  MemRead held in the EX/MEM register
exmem_MemWrite  in  1  MemWrite held in the EX/MEM register
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC register load enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX loads all-zero controls (bubble)
exmem_en  out  1  EX/MEM load enable
exmem_flush  out  1  EX/MEM loads all-zero controls
mem_req  out  1  data-memory access request
mem_err  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  saturating count of stall/freeze cycles
flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- State machine: RUN, MEM_WAIT, ERROR. Outputs are combinational from state and inputs (Mealy); state, counters and timer are registered.
- Reset:
  - Next state RUN; timer, stall_cnt, flush_cnt and mem_err are 0.
  - While rst=1, outputs are forced: all enables 1, all flushes 1, mem_req 0. The pipeline drains to NOPs.
  - Reset mid-MEM_WAIT or in ERROR returns to RUN on the next edge.
- Defaults (no event): all enables 1, all flushes 0.
- memop = exmem_MemRead | exmem_MemWrite.
- mem_req = memop in RUN and MEM_WAIT; 0 in ERROR.
- Freeze means pc_write=ifid_en=idex_en=exmem_en=0 and all flushes 0.
- Priority per cycle: freeze > branch flush > load-use stall.
- RUN:
  - memop & !mem_ready: freeze this cycle, timer<=1, next state MEM_WAIT, stall_cnt+1.
  - Else, if exmem_Branch & exmem_zero (taken branch):
    - pc_write=1 (PC takes the target).
    - ifid_flush=idex_flush=exmem_flush=1, all enables 1.
    - flush_cnt+1; any load-use condition is ignored that cycle.
  - Else, load-use: idex_MemRead & idex_rt!=0 & (idex_rt==id_rs | (id_uses_rt & idex_rt==id_rt)).
    - pc_write=0, ifid_en=0, idex_flush=1, exmem_en=1.
    - stall_cnt+1.
    - Exactly one bubble per hazard: on the next cycle the load has left ID/EX, so the condition clears.
  - Single-cycle memory (mem_ready with memop in the same cycle) produces no stall.
- MEM_WAIT:
  - Freeze every cycle while !mem_ready; stall_cnt+1 and timer+1 each such cycle.
  - On mem_ready: go to RUN, this cycle uses default enables (pipeline advances), timer<=0.
    - Branch and load-use evaluation resume in RUN.
  - If MEM_TIMEOUT!=0, timer==MEM_TIMEOUT and !mem_ready: go to ERROR and set mem_err<=1.
  - mem_ready wins when it coincides with the timeout.
- ERROR: freeze permanently, mem_req=0, mem_err=1, counters hold; exit only via rst.
- Counters saturate at all-ones and never wrap.

Decomposition:
- mips_pkg holds:
  - hazard_state_t enum {RUN, MEM_WAIT, ERROR};
  - REG_W=5;
  - default CNT_W;
  - a sat_inc function.
- One natural sub-module: hazard_lu_detect, a purely combinational load-use comparator instantiated by hazard_ctrl.

Test Plan:
- Load-use: idex_MemRead=1, idex_rt=8, id_rs=8 -> exactly one cycle with pc_write=0, ifid_en=0, idex_flush=1; stall_cnt 0->1; repeat with idex_rt=0 -> no stall.
- Taken branch: exmem_Branch=1, exmem_zero=1 while a load-use on rt=9 is also present -> all three flushes 1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: exmem_MemRead=1, mem_ready low 3 cycles then high -> 3 freeze cycles, advance on the 4th, stall_cnt=3, state RUN.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 after timer reaches 4, mem_req=0, freeze persists; rst pulse -> RUN, mem_err=0, counters 0.
- Saturation: CNT_W=4, 20 load-use stalls -> stall_cnt stops at 15.
- Reset in MEM_WAIT: rst asserted during the 2nd wait cycle -> all flushes 1 while rst=1, state RUN, timer 0 after release.
